// File: rtl/alu_issue_ctrl.sv
// alu_issue_ctrl: in-order issue/writeback scheduler for the integer ALU with RAW and writeback-port stalls
module alu_issue_ctrl #(
    parameter int DATA_W = 128,
    parameter int TAG_W  = 7,
    parameter int CNT_W  = 32
) (
    input  logic              clk_fake,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [5:0]        in_op,
    input  logic [TAG_W-1:0]  in_rt,
    input  logic [TAG_W-1:0]  in_ra,
    input  logic [TAG_W-1:0]  in_rb,
    input  logic [DATA_W-1:0] in_a,
    input  logic [DATA_W-1:0] in_b,
    output logic [5:0]        alu_op,
    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    input  logic [DATA_W-1:0] alu_result,
    output logic              wb_valid,
    output logic [TAG_W-1:0]  wb_tag,
    output logic [DATA_W-1:0] wb_data,
    output logic              err_illegal,
    output logic [CNT_W-1:0]  issue_count
);
    logic             legal, lat2, raw, acc, iss;
    logic             s2_v;
    logic [TAG_W-1:0] s2_t;
    assign legal = in_op inside {6'd4, 6'd6, 6'd8, 6'd28, 6'd30};
    assign lat2  = in_op == 6'd8;
    // slot 1 is the op writing back this cycle; no forwarding, so it still blocks readers
    assign raw   = (wb_valid && (in_ra == wb_tag || in_rb == wb_tag)) ||
                   (s2_v && (in_ra == s2_t || in_rb == s2_t));
    assign in_ready = !legal || !(raw || (!lat2 && s2_v));
    assign acc      = in_valid && in_ready;
    assign iss      = acc && legal;
    assign wb_data  = alu_result;
    always_ff @(posedge clk_fake or negedge rst_n) begin
        if (!rst_n) begin
            wb_valid    <= 1'b0;
            wb_tag      <= '0;
            s2_v        <= 1'b0;
            s2_t        <= '0;
            alu_op      <= '0;
            alu_a       <= '0;
            alu_b       <= '0;
            err_illegal <= 1'b0;
            issue_count <= '0;
        end else begin
            wb_valid    <= (iss && !lat2) || s2_v;
            wb_tag      <= (iss && !lat2) ? in_rt : s2_t;
            s2_v        <= iss && lat2;
            s2_t        <= (iss && lat2) ? in_rt : s2_t;
            alu_op      <= iss ? in_op : 6'd0;
            alu_a       <= iss ? in_a : alu_a;
            alu_b       <= iss ? in_b : alu_b;
            err_illegal <= acc && !legal;
            issue_count <= issue_count + CNT_W'(iss);
        end
    end
endmodule
